// File: rtl/dma_copy_engine.sv
// ---------------------------------------------------------------------------
// dma_copy_engine
//
// Block-copy engine sitting directly in front of the data memory. While idle
// it passes CPU loads and stores straight through to the memory. Once started,
// it copies dma_len bytes from dma_src to dma_dst in ascending address order.
// Each byte takes two cycles: a read cycle followed by a write cycle. The CPU
// is stalled until the copy completes.
//
// Optional feature, selected by the macro DMA_FILL_MODE_EN:
//   Adds the inputs dma_fill and dma_fill_val. When dma_fill is high at start,
//   the read cycles are skipped and every write stores dma_fill_val, so N
//   bytes take N cycles. Without the macro these ports do not exist.
//
// Ports
//   clock, reset   : system clock; synchronous active-high reset
//   cpu_addr       : CPU address, forwarded to memory while idle
//   cpu_wdata      : CPU store data, forwarded while idle
//   cpu_memWrite   : CPU store enable, forwarded while idle, dropped while busy
//   cpu_rdata      : CPU load data, always equal to mem_data_out
//   cpu_stall      : high while the engine is busy
//   dma_start      : one-cycle start request, honoured only while idle
//   dma_src        : source base address
//   dma_dst        : destination base address
//   dma_len        : byte count (0 completes immediately)
//   dma_busy       : engine not idle
//   dma_done       : one-cycle completion pulse
//   mem_addr       : memory address
//   mem_data_in    : memory write data
//   mem_memWrite   : memory write enable
//   mem_data_out   : memory combinational read data
//   dma_fill       : (fill build only) fill instead of copy
//   dma_fill_val   : (fill build only) byte written by a fill
// ---------------------------------------------------------------------------
module dma_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_memWrite,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_start,
  input  logic [AW-1:0] dma_src,
  input  logic [AW-1:0] dma_dst,
  input  logic [LW-1:0] dma_len,
`ifdef DMA_FILL_MODE_EN
  input  logic          dma_fill,
  input  logic [DW-1:0] dma_fill_val,
`endif
  output logic          dma_busy,
  output logic          dma_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_memWrite,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] srcPtr_q;
  logic [AW-1:0] dstPtr_q;
  logic [LW-1:0] remaining_q;
  logic [DW-1:0] hold_q;

  // startFill: the request being accepted is a fill.
  // fillMode:  the copy in progress is a fill (RD cycles are skipped).
  // In the copy-only build both are tied low and the fill paths vanish.
  logic startFill;
  logic fillMode;

`ifdef DMA_FILL_MODE_EN
  logic fill_q;

  assign startFill = dma_fill;
  assign fillMode  = fill_q;
`else
  assign startFill = 1'b0;
  assign fillMode  = 1'b0;
`endif

  // Main sequencer. A start is accepted only in IDLE; requests arriving in
  // any other state are ignored and their arguments are not latched. A fill
  // preloads hold_q with the fill byte, so the WR state needs no extra mux:
  // with RD skipped, hold_q simply keeps the fill value for the whole run.
  // The final WR is recognised by remaining_q == 1, before the decrement
  // lands, so DONE follows the last write directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      srcPtr_q    <= '0;
      dstPtr_q    <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
`ifdef DMA_FILL_MODE_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (dma_start) begin
            srcPtr_q    <= dma_src;
            dstPtr_q    <= dma_dst;
            remaining_q <= dma_len;
`ifdef DMA_FILL_MODE_EN
            fill_q      <= dma_fill;
            if (dma_fill) begin
              hold_q <= dma_fill_val;
            end
`endif
            if (dma_len == '0) begin
              state_q <= DONE;
            end else if (startFill) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end

        RD: begin
          hold_q  <= mem_data_out;
          state_q <= WR;
        end

        WR: begin
          srcPtr_q    <= srcPtr_q + AW'(1);
          dstPtr_q    <= dstPtr_q + AW'(1);
          remaining_q <= remaining_q - LW'(1);
          if (remaining_q == LW'(1)) begin
            state_q <= DONE;
          end else if (fillMode) begin
            state_q <= WR;
          end else begin
            state_q <= RD;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory port steering. IDLE forwards the CPU untouched. While busy, the
  // CPU store enable is never forwarded; RD and DONE keep the memory
  // write-disabled, and WR stores the held byte at the destination pointer.
  always_comb begin
    mem_addr     = cpu_addr;
    mem_data_in  = cpu_wdata;
    mem_memWrite = 1'b0;
    case (state_q)
      IDLE: begin
        mem_memWrite = cpu_memWrite;
      end
      RD: begin
        mem_addr = srcPtr_q;
      end
      WR: begin
        mem_addr     = dstPtr_q;
        mem_data_in  = hold_q;
        mem_memWrite = 1'b1;
      end
      default: begin
        mem_memWrite = 1'b0;
      end
    endcase
  end

  // Status outputs are plain decodes of the state register, so they are
  // glitch-free and change only on the clock edge.
  assign dma_busy  = (state_q != IDLE);
  assign cpu_stall = dma_busy;
  assign dma_done  = (state_q == DONE);
  assign cpu_rdata = mem_data_out;

endmodule

// File: tb/tb_dma_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_dma_copy_engine
//
// Bench for dma_copy_engine. A 256-byte memory with combinational read and
// clocked write sits behind the engine. A separate reference array holds what
// memory should contain, updated from the plain copy/fill rules: byte i of a
// run goes to (dst+i) mod 256, ascending, taking either the current reference
// byte at (src+i) mod 256 or the fill value. Completion timing is predicted
// from the byte count alone.
// ---------------------------------------------------------------------------
module tb_dma_copy_engine;

  logic       clock;
  logic       reset;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_memWrite;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       dma_start;
  logic [7:0] dma_src;
  logic [7:0] dma_dst;
  logic [7:0] dma_len;
`ifdef DMA_FILL_MODE_EN
  logic       dma_fill;
  logic [7:0] dma_fill_val;
`endif
  logic       dma_busy;
  logic       dma_done;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_memWrite;
  logic [7:0] mem_data_out;

  logic [7:0] mem    [256];
  logic [7:0] refMem [256];

  int compareCount = 0;
  int failCount    = 0;

  dma_copy_engine #(.AW(8), .DW(8), .LW(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_memWrite (cpu_memWrite),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .dma_start    (dma_start),
    .dma_src      (dma_src),
    .dma_dst      (dma_dst),
    .dma_len      (dma_len),
`ifdef DMA_FILL_MODE_EN
    .dma_fill     (dma_fill),
    .dma_fill_val (dma_fill_val),
`endif
    .dma_busy     (dma_busy),
    .dma_done     (dma_done),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_memWrite (mem_memWrite),
    .mem_data_out (mem_data_out)
  );

  // Clock: 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: combinational read, write on the rising edge.
  assign mem_data_out = mem[mem_addr];
  always_ff @(posedge clock) begin
    if (mem_memWrite) begin
      mem[mem_addr] <= mem_data_in;
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model of one run: ascending byte-by-byte, modulo 256.
  task automatic modelRun(input int src, input int dst, input int len,
                          input bit fill, input int fillVal);
    for (int i = 0; i < len; i++) begin
      refMem[(dst + i) % 256] = fill ? 8'(fillVal) : refMem[(src + i) % 256];
    end
  endtask

  // Expected cycle (counting the first cycle after the start edge as 1)
  // in which dma_done is high.
  function automatic int expectedDone(input int len, input bit fill);
    if (len == 0) return 1;
    return fill ? len + 1 : 2 * len + 1;
  endfunction

  // CPU store through the idle pass-through path; entered and left at negedge.
  task automatic cpuStore(input int addr, input int data);
    cpu_addr     = 8'(addr);
    cpu_wdata    = 8'(data);
    cpu_memWrite = 1'b1;
    @(negedge clock);
    cpu_memWrite = 1'b0;
    refMem[addr % 256] = 8'(data);
  endtask

  // CPU load check through the pass-through path.
  task automatic cpuLoadCheck(input string tag, input int addr);
    cpu_addr = 8'(addr);
    #1;
    checkOutput(tag, 32'(cpu_rdata), 32'(refMem[addr % 256]));
    @(negedge clock);
  endtask

  // Whole-memory comparison against the reference, counted as one check.
  task automatic compareMemory(input string tag);
    int diffs;
    diffs = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== refMem[a]) begin
        if (diffs == 0) begin
          $display("[TB] %s: first differing byte at 0x%02h: mem=0x%02h ref=0x%02h",
                   tag, a, mem[a], refMem[a]);
        end
        diffs++;
      end
    end
    checkOutput(tag, 32'(diffs), 32'd0);
  endtask

  // Issues one start request and watches the run. hazardMode: 0 none,
  // 1 directed (store 0x55->0x40 in cycle 2, rival start in cycle 3),
  // 2 random CPU stores and a random rival start in cycle 3.
  // resetAt > 0 pulses reset during that cycle. Returns the cycle in which
  // dma_done was seen (-1 if never), the count of busy non-done cycles and
  // the count of cycles with the memory write enable high.
  task automatic applyStimulus(input int src, input int dst, input int len,
                               input bit fill, input int fillVal,
                               input int hazardMode, input int resetAt,
                               output int doneAt, output int busyCount,
                               output int writeCount);
    dma_src   = 8'(src);
    dma_dst   = 8'(dst);
    dma_len   = 8'(len);
`ifdef DMA_FILL_MODE_EN
    dma_fill     = fill;
    dma_fill_val = 8'(fillVal);
`endif
    dma_start = 1'b1;
    @(negedge clock);
    dma_start  = 1'b0;
    doneAt     = -1;
    busyCount  = 0;
    writeCount = 0;
    for (int k = 1; k <= 600; k++) begin
      reset = (k == resetAt);
      cpu_memWrite = 1'b0;
      dma_start    = 1'b0;
      if (hazardMode == 1) begin
        if (k == 2) begin
          cpu_addr     = 8'h40;
          cpu_wdata    = 8'h55;
          cpu_memWrite = 1'b1;
        end
        if (k == 3) begin
          dma_src   = 8'h80;
          dma_dst   = 8'h90;
          dma_len   = 8'd7;
          dma_start = 1'b1;
        end
      end else if (hazardMode == 2) begin
        cpu_addr     = 8'($urandom_range(0, 255));
        cpu_wdata    = 8'($urandom_range(0, 255));
        cpu_memWrite = 1'($urandom_range(0, 1));
        if (k == 3) begin
          dma_src   = 8'($urandom_range(0, 255));
          dma_dst   = 8'($urandom_range(0, 255));
          dma_len   = 8'($urandom_range(1, 30));
          dma_start = 1'b1;
        end
      end
      #1;
      if (mem_memWrite) writeCount++;
      if (dma_done) begin
        doneAt = k;
        break;
      end
      if (resetAt > 0 && k == resetAt + 1) break;
      if (dma_busy) busyCount++;
      @(negedge clock);
    end
    reset        = 1'b0;
    cpu_memWrite = 1'b0;
    dma_start    = 1'b0;
  endtask

  // After a completed run: the next cycle must be idle with done low.
  task automatic checkIdleAfter(input string tag);
    @(negedge clock);
    #1;
    checkOutput({tag, "_idle"}, {30'd0, dma_busy, dma_done}, 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int doneAt, busyCount, writeCount;
    int src, dst, len, fillVal;
    bit fill;

    reset        = 1'b1;
    cpu_addr     = 8'h00;
    cpu_wdata    = 8'h00;
    cpu_memWrite = 1'b0;
    dma_start    = 1'b0;
    dma_src      = 8'h00;
    dma_dst      = 8'h00;
    dma_len      = 8'h00;
`ifdef DMA_FILL_MODE_EN
    dma_fill     = 1'b0;
    dma_fill_val = 8'h00;
`endif
    repeat (2) @(negedge clock);

    // Reset state and pass-through while idle.
    cpu_addr  = 8'h3C;
    cpu_wdata = 8'h9E;
    #1;
    checkOutput("reset_busy",  32'(dma_busy),  32'd0);
    checkOutput("reset_done",  32'(dma_done),  32'd0);
    checkOutput("reset_stall", 32'(cpu_stall), 32'd0);
    checkOutput("pass_addr",   32'(mem_addr),    32'h3C);
    checkOutput("pass_wdata",  32'(mem_data_in), 32'h9E);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Preload all of memory through the CPU path.
    for (int a = 0; a < 256; a++) begin
      cpuStore(a, $urandom_range(0, 255));
    end
    cpuStore(8'h10, 8'hA1);
    cpuStore(8'h11, 8'hB2);
    cpuStore(8'h12, 8'hC3);
    cpuStore(8'h13, 8'hD4);
    cpuStore(8'hFE, 8'h01);
    cpuStore(8'hFF, 8'h02);
    cpuStore(8'h00, 8'h03);
    cpuStore(8'h01, 8'h04);
    cpuLoadCheck("load_10", 8'h10);
    cpuLoadCheck("load_FF", 8'hFF);
    compareMemory("preload_mem");

    // Basic copy of four bytes.
    applyStimulus(8'h10, 8'h40, 4, 1'b0, 0, 0, 0, doneAt, busyCount, writeCount);
    modelRun(8'h10, 8'h40, 4, 1'b0, 0);
    checkOutput("copy4_done_cycle", 32'(doneAt), 32'(expectedDone(4, 1'b0)));
    checkOutput("copy4_busy_cycles", 32'(busyCount), 32'd8);
    checkOutput("copy4_writes", 32'(writeCount), 32'd4);
    checkIdleAfter("copy4");
    compareMemory("copy4_mem");

    // Zero-length start.
    applyStimulus(8'h20, 8'h60, 0, 1'b0, 0, 0, 0, doneAt, busyCount, writeCount);
    checkOutput("len0_done_cycle", 32'(doneAt), 32'd1);
    checkOutput("len0_writes", 32'(writeCount), 32'd0);
    checkIdleAfter("len0");
    compareMemory("len0_mem");

    // Address wrap on the source side.
    applyStimulus(8'hFE, 8'h02, 4, 1'b0, 0, 0, 0, doneAt, busyCount, writeCount);
    modelRun(8'hFE, 8'h02, 4, 1'b0, 0);
    checkOutput("wrap_done_cycle", 32'(doneAt), 32'd9);
    checkIdleAfter("wrap");
    compareMemory("wrap_mem");
    cpuLoadCheck("wrap_load_05", 8'h05);

    // Busy hazards: dropped store and ignored rival start.
    applyStimulus(8'h10, 8'h60, 4, 1'b0, 0, 1, 0, doneAt, busyCount, writeCount);
    modelRun(8'h10, 8'h60, 4, 1'b0, 0);
    checkOutput("hazard_done_cycle", 32'(doneAt), 32'd9);
    checkOutput("hazard_writes", 32'(writeCount), 32'd4);
    checkIdleAfter("hazard");
    compareMemory("hazard_mem");
    cpuStore(8'h80, 8'h55);
    cpuLoadCheck("store_after_done", 8'h80);

    // Reset in the third cycle of a four-byte copy.
    applyStimulus(8'h10, 8'hC0, 4, 1'b0, 0, 0, 3, doneAt, busyCount, writeCount);
    modelRun(8'h10, 8'hC0, 1, 1'b0, 0);
    checkOutput("midreset_no_done", 32'(doneAt), 32'hFFFF_FFFF);
    checkOutput("midreset_idle", 32'(dma_busy), 32'd0);
    checkOutput("midreset_writes", 32'(writeCount), 32'd1);
    @(negedge clock);
    compareMemory("midreset_mem");
    cpuStore(8'hC3, 8'h7B);
    cpuLoadCheck("midreset_pass", 8'hC3);

`ifdef DMA_FILL_MODE_EN
    // Fill of three bytes with zero.
    applyStimulus(8'h00, 8'h20, 3, 1'b1, 8'h00, 0, 0, doneAt, busyCount, writeCount);
    modelRun(8'h00, 8'h20, 3, 1'b1, 8'h00);
    checkOutput("fill3_done_cycle", 32'(doneAt), 32'd4);
    checkOutput("fill3_writes", 32'(writeCount), 32'd3);
    checkIdleAfter("fill3");
    compareMemory("fill3_mem");
`endif

    // Randomized runs, including overlaps and busy-time CPU noise.
    for (int it = 0; it < 24; it++) begin
      src     = $urandom_range(0, 255);
      dst     = ($urandom_range(0, 3) == 0) ? (src + $urandom_range(1, 3)) % 256
                                            : $urandom_range(0, 255);
      len     = $urandom_range(0, 24);
      fillVal = $urandom_range(0, 255);
`ifdef DMA_FILL_MODE_EN
      fill    = 1'($urandom_range(0, 1));
`else
      fill    = 1'b0;
`endif
      applyStimulus(src, dst, len, fill, fillVal, 2, 0, doneAt, busyCount, writeCount);
      modelRun(src, dst, len, fill, fillVal);
      checkOutput($sformatf("rand%0d_done_cycle", it), 32'(doneAt),
                  32'(expectedDone(len, fill)));
      checkOutput($sformatf("rand%0d_writes", it), 32'(writeCount), 32'(len));
      checkIdleAfter($sformatf("rand%0d", it));
      compareMemory($sformatf("rand%0d_mem", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
